// File: rtl/vga_data_gen_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
package vga_data_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DOUT_W = 16;

  // The counter is sized to hold DATA_DEPTH itself, so it never wraps within a frame.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vga_start_edge_det.sv
// Rising-edge detector on the frame start request.
// start_d is the registered copy of start_i. start_pulse is high in the
// first cycle that start_i is seen high after being low.
module vga_start_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic start_pulse
);

  logic start_d;

  // Delay start_i by one cycle so that a rising edge can be detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d <= 1'b0;
    end else begin
      start_d <= start_i;
    end
  end

  assign start_pulse = start_i & ~start_d;

endmodule

// File: rtl/vga_data_gen.sv
// Test-pattern source for the SDRAM frame-buffer writer.
// Each start request streams DATA_DEPTH words. The value of each word is the
// per-frame base plus the running index. The base advances by SPAN_NUM after
// every frame, so the picture scrolls from one frame to the next.
// Optional build macro VGA_GEN_DONE_EN adds the frame_done_o pulse output.
module vga_data_gen
  import vga_data_gen_pkg::*;
#(
  parameter int DATA_DEPTH = 1024 * 768,
  parameter int SPAN_NUM   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              wr_en,
`ifdef VGA_GEN_DONE_EN
  output logic              frame_done_o,
`endif
  output logic              data_en,
  output logic [DOUT_W-1:0] dout
);

  localparam int                CNT_W    = cnt_width(DATA_DEPTH);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_DEPTH - 1);
  localparam logic [DOUT_W-1:0] SPAN     = DOUT_W'(SPAN_NUM);

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [DOUT_W-1:0] base;
  logic              start_pulse;
  logic              last_beat;

  vga_start_edge_det u_start_edge (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .start_pulse (start_pulse)
  );

  // A beat moves on every edge where a frame is active and memory is ready.
  // Stalls therefore cost nothing.
  assign data_en   = (state == RUN) & wr_en;
  assign last_beat = data_en & (counter == LAST_IDX);

  // Frame sequencer. dout always holds the next word to be sent. While idle
  // it holds the base for the next frame. A start edge seen during a frame
  // is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      base    <= '0;
      dout    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pulse) begin
            state   <= RUN;
            counter <= '0;
            dout    <= base;
          end
        end
        RUN: begin
          if (last_beat) begin
            state   <= IDLE;
            counter <= '0;
            base    <= base + SPAN;
            dout    <= base + SPAN;
          end else if (data_en) begin
            counter <= counter + CNT_W'(1);
            dout    <= dout + DOUT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef VGA_GEN_DONE_EN
  // Single-cycle pulse in the cycle after the final beat of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= last_beat;
    end
  end
`endif

endmodule

// File: tb/tb_vga_data_gen.sv
// Directed and randomized checks of vga_data_gen with DATA_DEPTH=16 and
// SPAN_NUM=9. A frame/beat reference model predicts every output.
module tb_vga_data_gen;

  localparam int DEPTH = 16;
  localparam int SPAN  = 9;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        wr_en;
  logic        data_en;
  logic [15:0] dout;
`ifdef VGA_GEN_DONE_EN
  logic        frame_done_o;
`endif

  int  assertCount = 0;
  int  failCount   = 0;

  // Reference model: frame number, beat index within the frame, and activity flag
  int  mf;
  int  mk;
  bit  mrun;
  bit  mstartPrev;
  bit  mdone;
  int  beatsSeen;

  vga_data_gen #(
    .DATA_DEPTH (DEPTH),
    .SPAN_NUM   (SPAN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .wr_en        (wr_en),
`ifdef VGA_GEN_DONE_EN
    .frame_done_o (frame_done_o),
`endif
    .data_en      (data_en),
    .dout         (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the DUT outputs with the values the model predicts for this cycle.
  task automatic checkOutput(input string tag);
    logic        expEn;
    logic [15:0] expDout;
    expEn   = mrun && wr_en && !rst;
    expDout = 16'((mf * SPAN + (mrun ? mk : 0)) % 65536);
    assertCount++;
    assert (data_en === expEn) else begin
      failCount++;
      $error("[TB] FAIL %s data_en got %b want %b (frame %0d beat %0d)", tag, data_en, expEn, mf, mk);
    end
    assertCount++;
    assert (dout === expDout) else begin
      failCount++;
      $error("[TB] FAIL %s dout got %h want %h (frame %0d beat %0d)", tag, dout, expDout, mf, mk);
    end
`ifdef VGA_GEN_DONE_EN
    assertCount++;
    assert (frame_done_o === mdone) else begin
      failCount++;
      $error("[TB] FAIL %s frame_done_o got %b want %b", tag, frame_done_o, mdone);
    end
`endif
  endtask

  // Drive one cycle of inputs and check the outputs. Then advance the model
  // across the following rising edge.
  task automatic applyStimulus(input logic s, input logic w, input string tag);
    bit pulse;
    @(negedge clk);
    start_i = s;
    wr_en   = w;
    #1;
    checkOutput(tag);
    if (data_en === 1'b1) beatsSeen++;
    pulse = s && !mstartPrev;
    mdone = 1'b0;
    if (mrun && w) begin
      mk++;
      if (mk == DEPTH) begin
        mrun  = 1'b0;
        mk    = 0;
        mf++;
        mdone = 1'b1;
      end
    end else if (!mrun && pulse) begin
      mrun = 1'b1;
      mk   = 0;
    end
    mstartPrev = s;
  endtask

  // Assert reset mid-cycle, check that outputs clear at once, then release it.
  task automatic applyReset(input string tag);
    @(negedge clk);
    #2;
    rst     = 1'b1;
    start_i = 1'b0;
    mf = 0; mk = 0; mrun = 1'b0; mstartPrev = 1'b0; mdone = 1'b0;
    #1;
    checkOutput(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare the number of beats seen in a frame with the frame length.
  task automatic checkBeats(input string tag);
    assertCount++;
    assert (beatsSeen === DEPTH) else begin
      failCount++;
      $error("[TB] FAIL %s beat count got %0d want %0d", tag, beatsSeen, DEPTH);
    end
    beatsSeen = 0;
  endtask

  // Record a failure when a frame has not completed within its cycle budget.
  task automatic checkTimeout(input bit stillRunning, input string tag);
    assertCount++;
    assert (!stillRunning) else begin
      failCount++;
      $error("[TB] FAIL %s frame did not complete within cycle budget", tag);
    end
  endtask

  initial begin
    int i;
    rst = 1'b0; start_i = 1'b0; wr_en = 1'b0;
    mf = 0; mk = 0; mrun = 1'b0; mstartPrev = 1'b0; mdone = 1'b0; beatsSeen = 0;

    applyReset("reset");
    applyStimulus(1'b0, 1'b1, "idle_after_reset");

    // Frame 0: start held for 3 cycles. wr_en is low 8, high 5, low 15, then high.
    i = 0;
    do begin
      applyStimulus(logic'(i < 3), logic'((i >= 8 && i < 13) || i >= 28), "f0");
      i++;
    end while ((mrun || i < 3) && i < 200);
    checkTimeout(mrun, "f0_timeout");
    checkBeats("f0_beats");
    for (int j = 0; j < 10; j++) applyStimulus(1'b0, 1'b1, "f0_idle");
    beatsSeen = 0;

    // Frame 1: wr_en toggles every cycle. start stays high past the end of the frame.
    i = 0;
    do begin
      applyStimulus(1'b1, logic'(i % 2), "f1");
      i++;
    end while (mrun && i < 200);
    checkTimeout(mrun, "f1_timeout");
    checkBeats("f1_beats");
    for (int j = 0; j < 6; j++) applyStimulus(1'b1, 1'b1, "f1_held_start");
    applyStimulus(1'b0, 1'b1, "f1_release");

    // Frame 2: random wr_en, with an extra start pulse at beat 5.
    applyStimulus(1'b1, 1'b0, "f2_start");
    i = 0;
    while (mrun && i < 300) begin
      applyStimulus(logic'(mk == 5), logic'($urandom_range(0, 1)), "f2");
      i++;
    end
    checkTimeout(mrun, "f2_timeout");
    checkBeats("f2_beats");
    applyStimulus(1'b0, 1'b1, "f2_idle");

    // Frame 3: reset at beat 7 aborts the frame and clears the base.
    applyStimulus(1'b1, 1'b1, "f3_start");
    i = 0;
    while (mk < 7 && i < 300) begin
      applyStimulus(1'b0, logic'($urandom_range(0, 1)), "f3");
      i++;
    end
    applyReset("f3_abort");
    beatsSeen = 0;
    applyStimulus(1'b0, 1'b1, "f3_post_reset");

    // New frame after the reset starts from value 0. A start edge arrives
    // together with the last beat and must be ignored.
    applyStimulus(1'b1, 1'b0, "f4_start");
    i = 0;
    while (mrun && i < 300) begin
      if (mk == DEPTH - 1) applyStimulus(1'b1, 1'b1, "f4_last_pulse");
      else                 applyStimulus(1'b0, logic'($urandom_range(0, 1)), "f4");
      i++;
    end
    checkTimeout(mrun, "f4_timeout");
    checkBeats("f4_beats");
    for (int j = 0; j < 5; j++) applyStimulus(1'b1, 1'b1, "f4_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
